// File: rtl/fft_iter_core.sv
// fft_iter_core: in-place iterative radix-2 DIT FFT over N = 2^N_LOG2 complex samples.
// Samples are loaded in bit-reversed order, one butterfly is computed every two cycles
// on an internal register array, and the spectrum is streamed out in natural order.
module fft_iter_core #(
    parameter int N_LOG2 = 4,
    parameter int DW     = 24,
    parameter int TW     = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 scale_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 busy,
    output logic                 ovf
);
    localparam int N  = 1 << N_LOG2;
    localparam int KW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
    localparam int AW = DW + 1;
    localparam int PW = DW + TW + 1;

    localparam logic [N_LOG2-1:0] One     = N_LOG2'(1);
    localparam logic [N_LOG2-1:0] LastIdx = {N_LOG2{1'b1}};
    localparam logic [KW-1:0]     LastK   = {KW{1'b1}};
    localparam logic [SW-1:0]     LastS   = SW'(N_LOG2 - 1);

    localparam real Pi = 3.14159265358979323846;

    typedef enum logic [1:0] {StLoad, StBfRd, StBfWr, StUnload} state_t;

    // Twiddle value in Q2.(TW-2), rounded to nearest; series form keeps it elaboration-only.
    function automatic int tw_calc(input int t, input bit want_im);
        real x, x2, term_c, term_s, acc_c, acc_s, v;
        x      = 2.0 * Pi * $itor(t) / $itor(N);
        x2     = x * x;
        term_c = 1.0;
        term_s = x;
        acc_c  = 1.0;
        acc_s  = x;
        for (int i = 1; i < 16; i++) begin
            term_c = -term_c * x2 / $itor((2 * i - 1) * (2 * i));
            term_s = -term_s * x2 / $itor((2 * i) * (2 * i + 1));
            acc_c  = acc_c + term_c;
            acc_s  = acc_s + term_s;
        end
        v = (want_im ? -acc_s : acc_c) * $itor(1 << (TW - 2));
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
        return r;
    endfunction

    function automatic logic clips(input logic signed [DW:0] v);
        return v[DW] != v[DW-1];
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
        if (clips(v)) return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return v[DW-1:0];
    endfunction

    // Sample store; deliberately not reset.
    logic signed [DW-1:0] r_mem_re [N];
    logic signed [DW-1:0] r_mem_im [N];

    logic signed [TW-1:0] w_rom_re [N/2];
    logic signed [TW-1:0] w_rom_im [N/2];

    for (genvar g = 0; g < N / 2; g++) begin : g_rom
        localparam int TwRe = tw_calc(g, 1'b0);
        localparam int TwIm = tw_calc(g, 1'b1);
        assign w_rom_re[g] = TwRe[TW-1:0];
        assign w_rom_im[g] = TwIm[TW-1:0];
    end

    state_t               r_state;
    logic [N_LOG2-1:0]    r_cnt;
    logic [KW-1:0]        r_k;
    logic [SW-1:0]        r_s;
    logic                 r_scale;
    logic                 r_ovf;
    logic signed [DW-1:0] r_a_re, r_a_im;
    logic signed [AW-1:0] r_p_re, r_p_im;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_re, r_out_im;
    logic                 r_out_last;
    logic                 r_busy;

    logic [N_LOG2-1:0]    w_k_ext, w_span, w_low, w_addr_a, w_addr_b, w_cnt_inc;
    logic [KW-1:0]        w_tw_idx;
    logic signed [DW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [TW-1:0] w_tw_re, w_tw_im;
    logic signed [PW-1:0] w_pr_full, w_pi_full;
    logic signed [AW-1:0] w_p_re, w_p_im;
    logic signed [AW-1:0] w_sa_re, w_sa_im, w_sb_re, w_sb_im;
    logic signed [DW-1:0] w_na_re, w_na_im, w_nb_re, w_nb_im;
    logic                 w_clip;
    logic                 w_accept;
    logic                 w_out_hs;

    assign w_accept  = in_valid & r_in_ready;
    assign w_out_hs  = r_out_valid & out_ready;
    assign w_cnt_inc = r_cnt + One;

    // Butterfly addressing and twiddle index for the current (stage, k).
    always_comb begin
        w_k_ext  = {1'b0, r_k};
        w_span   = One << r_s;
        w_low    = w_k_ext & (w_span - One);
        w_addr_a = (((w_k_ext >> r_s) << r_s) << 1) | w_low;
        w_addr_b = w_addr_a | w_span;
        w_tw_idx = KW'(w_low << (LastS - r_s));
    end

    // Operand fetch and full-precision complex product B*W, floored back to Q0.
    always_comb begin
        w_a_re    = r_mem_re[w_addr_a];
        w_a_im    = r_mem_im[w_addr_a];
        w_b_re    = r_mem_re[w_addr_b];
        w_b_im    = r_mem_im[w_addr_b];
        w_tw_re   = w_rom_re[w_tw_idx];
        w_tw_im   = w_rom_im[w_tw_idx];
        w_pr_full = PW'(w_b_re) * PW'(w_tw_re) - PW'(w_b_im) * PW'(w_tw_im);
        w_pi_full = PW'(w_b_re) * PW'(w_tw_im) + PW'(w_b_im) * PW'(w_tw_re);
        w_p_re    = AW'(w_pr_full >>> (TW - 2));
        w_p_im    = AW'(w_pi_full >>> (TW - 2));
    end

    // Butterfly sums with either halving or saturation back to DW bits.
    always_comb begin
        w_sa_re = {r_a_re[DW-1], r_a_re} + r_p_re;
        w_sa_im = {r_a_im[DW-1], r_a_im} + r_p_im;
        w_sb_re = {r_a_re[DW-1], r_a_re} - r_p_re;
        w_sb_im = {r_a_im[DW-1], r_a_im} - r_p_im;
        w_clip  = 1'b0;
        if (r_scale) begin
            w_na_re = w_sa_re[DW:1];
            w_na_im = w_sa_im[DW:1];
            w_nb_re = w_sb_re[DW:1];
            w_nb_im = w_sb_im[DW:1];
        end else begin
            w_na_re = sat(w_sa_re);
            w_na_im = sat(w_sa_im);
            w_nb_re = sat(w_sb_re);
            w_nb_im = sat(w_sb_im);
            w_clip  = clips(w_sa_re) | clips(w_sa_im) | clips(w_sb_re) | clips(w_sb_im);
        end
    end

    // Sample store writes: bit-reversed load, in-place butterfly write-back.
    always_ff @(posedge clk) begin
        if (r_state == StLoad && w_accept) begin
            r_mem_re[bitrev(r_cnt)] <= in_re;
            r_mem_im[bitrev(r_cnt)] <= in_im;
        end else if (r_state == StBfWr) begin
            r_mem_re[w_addr_a] <= w_na_re;
            r_mem_im[w_addr_a] <= w_na_im;
            r_mem_re[w_addr_b] <= w_nb_re;
            r_mem_im[w_addr_b] <= w_nb_im;
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StLoad;
            r_cnt       <= '0;
            r_k         <= '0;
            r_s         <= '0;
            r_scale     <= 1'b0;
            r_ovf       <= 1'b0;
            r_a_re      <= '0;
            r_a_im      <= '0;
            r_p_re      <= '0;
            r_p_im      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StLoad: begin
                    if (w_accept) begin
                        if (r_cnt == '0) r_ovf <= 1'b0;
                        if (r_cnt == LastIdx) begin
                            r_scale    <= scale_en;
                            r_cnt      <= '0;
                            r_k        <= '0;
                            r_s        <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= StBfRd;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                StBfRd: begin
                    r_a_re  <= w_a_re;
                    r_a_im  <= w_a_im;
                    r_p_re  <= w_p_re;
                    r_p_im  <= w_p_im;
                    r_state <= StBfWr;
                end
                StBfWr: begin
                    if (w_clip) r_ovf <= 1'b1;
                    if (r_k == LastK) begin
                        r_k <= '0;
                        if (r_s == LastS) begin
                            // Last butterfly touches addresses N/2-1 and N-1, so bin 0 is final.
                            r_cnt       <= '0;
                            r_out_valid <= 1'b1;
                            r_out_re    <= r_mem_re[0];
                            r_out_im    <= r_mem_im[0];
                            r_out_last  <= 1'b0;
                            r_state     <= StUnload;
                        end else begin
                            r_s     <= r_s + 1'b1;
                            r_state <= StBfRd;
                        end
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= StBfRd;
                    end
                end
                StUnload: begin
                    if (w_out_hs) begin
                        if (r_cnt == LastIdx) begin
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_re    <= '0;
                            r_out_im    <= '0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= StLoad;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_out_re   <= r_mem_re[w_cnt_inc];
                            r_out_im   <= r_mem_im[w_cnt_inc];
                            r_out_last <= (w_cnt_inc == LastIdx);
                        end
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_fft_iter_core.sv
// Directed bench for fft_iter_core (N=16): expected bins are queued when a frame is
// sent and popped as the core streams the spectrum out.
module tb_fft_iter_core;
    localparam int N_LOG2 = 4;
    localparam int DW     = 24;
    localparam int TW     = 14;
    localparam int N      = 1 << N_LOG2;
    localparam real Pi    = 3.14159265358979323846;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re, in_im;
    logic                 scale_en;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re, out_im;
    logic                 out_last;
    logic                 busy;
    logic                 ovf;

    typedef struct {
        int     k;
        longint re;
        longint im;
        int     tol;
    } exp_t;

    exp_t sb_q[$];
    int   f_re[N];
    int   f_im[N];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   last_acc = 0;

    fft_iter_core #(
        .N_LOG2 (N_LOG2),
        .DW     (DW),
        .TW     (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .scale_en  (scale_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv, input int tol);
        logic signed [63:0] d;
        d = obs - expv;
        n_total++;
        assert ((d <= tol) && (d >= -tol)) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    function automatic longint rnd(input real v);
        if (v >= 0.0) return longint'($rtoi(v + 0.5));
        return -longint'($rtoi(0.5 - v));
    endfunction

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) begin
            f_re[i] = v;
            f_im[i] = 0;
        end
    endtask

    task automatic push_bin(input int k, input longint re, input longint im, input int tol);
        exp_t e;
        e.k   = k;
        e.re  = re;
        e.im  = im;
        e.tol = tol;
        sb_q.push_back(e);
    endtask

    // Feed one frame; scale_en carries the requested mode only on the last sample.
    task automatic send_frame(input bit scale, input int gap_pct, input bit chk_clr);
        int w;
        for (int n = 0; n < N; n++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_re    = f_re[n];
            in_im    = f_im[n];
            scale_en = (n == N - 1) ? scale : ~scale;
            w = 0;
            while (!in_ready && w < 300) begin
                tick();
                w++;
            end
            if (!in_ready) begin
                $display("FAIL load_timeout observed=in_ready_low required=in_ready_high");
                $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
                $fatal(1, "load timeout");
            end
            last_acc = cyc;
            tick();
            if (n == 0 && chk_clr) chk("ovf_clear_on_accept", ovf, 0, 0);
        end
        in_valid = 1'b0;
        scale_en = 1'b0;
    endtask

    // Collect N bins with optional output stalls; checks latency, hold and scoreboard.
    task automatic drain(input int stall_pct, input bit chk_lat, input bit exp_ovf);
        int                 got, waited;
        bit                 first, prev_stall;
        logic signed [63:0] p_re, p_im, p_last;
        exp_t               e;
        got        = 0;
        waited     = 0;
        first      = 1'b1;
        prev_stall = 1'b0;
        p_re       = 0;
        p_im       = 0;
        p_last     = 0;
        while (got < N && waited < 3000) begin
            out_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            if (waited == 5 && !out_valid) begin
                chk("busy_in_compute", busy, 1, 0);
                chk("in_ready_in_compute", in_ready, 0, 0);
                chk("out_re_idle_zero", out_re, 0, 0);
            end
            if (prev_stall) begin
                chk("stall_valid_hold", out_valid, 1, 0);
                chk("stall_re_hold", out_re, p_re, 0);
                chk("stall_im_hold", out_im, p_im, 0);
                chk("stall_last_hold", out_last, p_last, 0);
            end
            if (out_valid) begin
                if (first) begin
                    first = 1'b0;
                    if (chk_lat) chk("first_out_latency", cyc - last_acc, 1 + N * N_LOG2, 0);
                    chk("ovf_in_unload", ovf, exp_ovf, 0);
                    chk("busy_in_unload", busy, 1, 0);
                    chk("in_ready_in_unload", in_ready, 0, 0);
                end
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", got, N, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("bin%0d_re", e.k), out_re, e.re, e.tol);
                        chk($sformatf("bin%0d_im", e.k), out_im, e.im, e.tol);
                        chk($sformatf("bin%0d_last", e.k), out_last, (e.k == N - 1), 0);
                    end
                    got++;
                end
                prev_stall = !out_ready;
                p_re       = out_re;
                p_im       = out_im;
                p_last     = out_last;
            end else begin
                prev_stall = 1'b0;
            end
            tick();
            waited++;
        end
        out_ready = 1'b0;
        if (got < N) chk("drain_timeout", got, N, 0);
        chk("post_unload_in_ready", in_ready, 1, 0);
        chk("post_unload_out_valid", out_valid, 0, 0);
        sb_q.delete();
    endtask

    task automatic push_tone();
        for (int k = 0; k < N; k++) begin
            push_bin(k, rnd(1000.0 * $cos(2.0 * Pi * k / N)),
                     rnd(-1000.0 * $sin(2.0 * Pi * k / N)), (k % 4 == 0) ? 0 : 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        scale_en  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1, 0);
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_out_re", out_re, 0, 0);
        chk("rst_out_im", out_im, 0, 0);
        chk("rst_out_last", out_last, 0, 0);
        chk("rst_busy", busy, 0, 0);
        chk("rst_ovf", ovf, 0, 0);
        rst = 1'b0;
        tick();

        // Impulse, unscaled: flat spectrum of 1000.
        fill(0);
        f_re[0] = 1000;
        for (int k = 0; k < N; k++) push_bin(k, 1000, 0, 0);
        send_frame(1'b0, 0, 1'b0);
        drain(0, 1'b1, 1'b0);

        // Impulse, scaled: 1000 halved four times with floor.
        for (int k = 0; k < N; k++) push_bin(k, 62, 0, 0);
        send_frame(1'b1, 0, 1'b0);
        drain(0, 1'b1, 1'b0);

        // DC: all energy in bin 0.
        fill(100);
        for (int k = 0; k < N; k++) push_bin(k, (k == 0) ? 1600 : 0, 0, 0);
        send_frame(1'b0, 0, 1'b0);
        drain(0, 1'b1, 1'b0);

        // Single tone at bin 1.
        fill(0);
        f_re[1] = 1000;
        push_tone();
        send_frame(1'b0, 0, 1'b0);
        drain(0, 1'b0, 1'b0);

        // Full-scale DC, unscaled: bin 0 saturates and ovf is raised.
        fill(8388607);
        for (int k = 0; k < N; k++) push_bin(k, (k == 0) ? 8388607 : 0, 0, 0);
        send_frame(1'b0, 0, 1'b0);
        drain(0, 1'b0, 1'b1);
        chk("ovf_sticky_after_unload", ovf, 1, 0);

        // Full-scale DC, scaled: no clipping; ovf cleared by the first accept.
        for (int k = 0; k < N; k++) push_bin(k, (k == 0) ? 8388607 : 0, 0, 0);
        send_frame(1'b1, 0, 1'b1);
        drain(0, 1'b0, 1'b0);

        // Tone again with random input gaps and output stalls.
        fill(0);
        f_re[1] = 1000;
        push_tone();
        send_frame(1'b0, 30, 1'b0);
        drain(40, 1'b0, 1'b0);

        // Reset in the middle of a clipping computation.
        fill(8388607);
        send_frame(1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("midrun_busy", busy, 1, 0);
        chk("midrun_ovf", ovf, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1, 0);
        chk("midrst_out_valid", out_valid, 0, 0);
        chk("midrst_ovf", ovf, 0, 0);
        chk("midrst_busy", busy, 0, 0);
        tick();

        // Frame after the reset computes correctly.
        fill(100);
        for (int k = 0; k < N; k++) push_bin(k, (k == 0) ? 1600 : 0, 0, 0);
        send_frame(1'b0, 0, 1'b0);
        drain(0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
